// File: rtl/exp5_pkg.sv
// Shared definitions for the memory-game control unit: state codes and defaults.
package exp5_pkg;

    // Default number of cycles a player may wait in espera before losing.
    localparam int unsigned TIMEOUT_CICLOS_DEF = 5000;

    // State codes double as the debug display value on db_estado.
    typedef enum logic [3:0] {
        st_inicial        = 4'h0,
        st_preparacao     = 4'h1,
        st_inicia_rodada  = 4'h2,
        st_espera         = 4'h3,
        st_registra       = 4'h4,
        st_comparacao     = 4'h5,
        st_proximo        = 4'h6,
        st_proxima_rodada = 4'h7,
        st_fim_acertou    = 4'hA,
        st_fim_errou      = 4'hB,
        st_fim_timeout    = 4'hC
    } estado_t;

    // Debug code shown when the state register holds an unassigned code.
    localparam logic [3:0] DB_ILEGAL = 4'hF;

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: one-cycle pulse when sinal goes from 0 to 1.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sinal,
    output logic pulso
);

    logic sinal_q;
    logic sinal_d;

    // Previous-cycle copy of the input and the resulting edge pulse.
    always_comb begin
        sinal_d = sinal;
        pulso   = sinal & ~sinal_q;
    end

    // Delay flop, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sinal_q <= 1'b0;
        end else begin
            sinal_q <= sinal_d;
        end
    end

endmodule

// File: rtl/exp5_unidade_controle.sv
// Moore control unit for the rounds-based memory game; drives datapath strobes.
module exp5_unidade_controle
    import exp5_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF,
    parameter int unsigned TW             = $clog2(TIMEOUT_CICLOS)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    estado_t         estado_q;
    estado_t         estado_d;
    logic [TW-1:0]   tmo_cnt_q;
    logic [TW-1:0]   tmo_cnt_d;
    logic            jp;
    logic            tmo_max;
    logic            tmo;

    // Button presses are reduced to a single-cycle pulse; a held button never repeats.
    edge_detector u_edge_jogada (
        .clock (clock),
        .reset (reset),
        .sinal (jogada),
        .pulso (jp)
    );

    // Per-play timeout counter: cleared before each wait, saturates at the limit.
    always_comb begin
        tmo_max   = (tmo_cnt_q == TW'(TIMEOUT_CICLOS - 1));
        tmo       = tmo_max && (estado_q == st_espera);
        tmo_cnt_d = tmo_cnt_q;
        case (estado_q)
            st_preparacao, st_inicia_rodada, st_proximo: tmo_cnt_d = '0;
            st_espera: begin
                if (!tmo_max) begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            default: tmo_cnt_d = tmo_cnt_q;
        endcase
    end

    // Next-state logic and Moore outputs; unassigned codes fall back to inicial.
    always_comb begin
        estado_d  = st_inicial;
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        pronto    = 1'b0;
        db_estado = DB_ILEGAL;
        case (estado_q)
            st_inicial: begin
                zeraE     = 1'b1;
                zeraL     = 1'b1;
                zeraR     = 1'b1;
                db_estado = estado_q;
                estado_d  = iniciar ? st_preparacao : st_inicial;
            end
            st_preparacao: begin
                zeraE     = 1'b1;
                zeraL     = 1'b1;
                zeraR     = 1'b1;
                db_estado = estado_q;
                estado_d  = st_inicia_rodada;
            end
            st_inicia_rodada: begin
                zeraE     = 1'b1;
                db_estado = estado_q;
                estado_d  = st_espera;
            end
            st_espera: begin
                db_estado = estado_q;
                if (jp) begin
                    estado_d = st_registra;
                end else if (tmo) begin
                    estado_d = st_fim_timeout;
                end else begin
                    estado_d = st_espera;
                end
            end
            st_registra: begin
                registraR = 1'b1;
                db_estado = estado_q;
                estado_d  = st_comparacao;
            end
            st_comparacao: begin
                db_estado = estado_q;
                if (!igual) begin
                    estado_d = st_fim_errou;
                end else if (!fimE) begin
                    estado_d = st_proximo;
                end else if (!fimL) begin
                    estado_d = st_proxima_rodada;
                end else begin
                    estado_d = st_fim_acertou;
                end
            end
            st_proximo: begin
                contaE    = 1'b1;
                db_estado = estado_q;
                estado_d  = st_espera;
            end
            st_proxima_rodada: begin
                contaL    = 1'b1;
                db_estado = estado_q;
                estado_d  = st_inicia_rodada;
            end
            st_fim_acertou: begin
                pronto    = 1'b1;
                acertou   = 1'b1;
                db_estado = estado_q;
                estado_d  = iniciar ? st_preparacao : st_fim_acertou;
            end
            st_fim_errou: begin
                pronto    = 1'b1;
                errou     = 1'b1;
                db_estado = estado_q;
                estado_d  = iniciar ? st_preparacao : st_fim_errou;
            end
            st_fim_timeout: begin
                pronto    = 1'b1;
                timeout   = 1'b1;
                db_estado = estado_q;
                estado_d  = iniciar ? st_preparacao : st_fim_timeout;
            end
            default: begin
                db_estado = DB_ILEGAL;
                estado_d  = st_inicial;
            end
        endcase
    end

    // State and timeout-counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= st_inicial;
            tmo_cnt_q <= '0;
        end else begin
            estado_q  <= estado_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_exp5_unidade_controle.sv
// Directed bench for exp5_unidade_controle with a 4-position datapath model.
module tb_exp5_unidade_controle;
    import exp5_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fimE;
    logic       fimL;
    logic       zeraE;
    logic       contaE;
    logic       zeraL;
    logic       contaL;
    logic       zeraR;
    logic       registraR;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic       pronto;
    logic [3:0] db_estado;

    logic [1:0] botao;
    logic [1:0] e_q;
    logic [1:0] l_q;
    logic [1:0] r_q;
    logic [1:0] mem [0:3] = '{2'd2, 2'd1, 2'd3, 2'd0};

    int checks = 0;
    int failures = 0;
    int cnt_conta_e = 0;
    int cnt_conta_l = 0;
    int base_e;
    int base_l;

    exp5_unidade_controle #(.TIMEOUT_CICLOS(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .jogada    (jogada),
        .igual     (igual),
        .fimE      (fimE),
        .fimL      (fimL),
        .zeraE     (zeraE),
        .contaE    (contaE),
        .zeraL     (zeraL),
        .contaL    (contaL),
        .zeraR     (zeraR),
        .registraR (registraR),
        .acertou   (acertou),
        .errou     (errou),
        .timeout   (timeout),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // Datapath model: address counter E, round limit L, play register R.
    always @(posedge clock) begin
        if (zeraE) e_q <= 2'd0;
        else if (contaE) e_q <= e_q + 2'd1;
        if (zeraL) l_q <= 2'd0;
        else if (contaL) l_q <= l_q + 2'd1;
        if (zeraR) r_q <= 2'd0;
        else if (registraR) r_q <= botao;
        if (contaE) cnt_conta_e <= cnt_conta_e + 1;
        if (contaL) cnt_conta_l <= cnt_conta_l + 1;
    end

    assign igual = (r_q == mem[e_q]);
    assign fimE  = (e_q == l_q);
    assign fimL  = (l_q == 2'd3);

    task automatic tick;
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [3:0] code, input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (db_estado !== code && n < budget) begin
            tick;
            n++;
        end
        chk(tag, 8'(db_estado), 8'(code));
    endtask

    // One press in espera: registra after one edge, comparacao after the next.
    task automatic play(input logic [1:0] v, input string tag);
        wait_state(4'h3, 40, {tag, "_espera"});
        jogada = 1'b1;
        botao  = v;
        tick;
        chk({tag, "_registraR"}, 8'(registraR), 8'd1);
        jogada = 1'b0;
        tick;
        chk({tag, "_comparacao"}, 8'(db_estado), 8'h5);
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b0;
        jogada  = 1'b0;
        botao   = 2'd0;
        tick;
        tick;
        reset = 1'b0;
        tick;

        // Test 1: reset asserted while in espera.
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        chk("prep", 8'(db_estado), 8'h1);
        tick;
        chk("inicia_rodada", 8'(db_estado), 8'h2);
        tick;
        chk("espera_before_reset", 8'(db_estado), 8'h3);
        reset = 1'b1;
        tick;
        tick;
        reset = 1'b0;
        chk("rst_db", 8'(db_estado), 8'h0);
        chk("rst_zeras", 8'({zeraE, zeraL, zeraR}), 8'h7);
        chk("rst_pronto", 8'(pronto), 8'h0);
        chk("rst_others", 8'({contaE, contaL, registraR, acertou, errou, timeout}), 8'h0);
        tick;
        chk("inicial_holds", 8'(db_estado), 8'h0);

        // Test 2: full win, 10 correct plays over rounds 0..3.
        base_e  = cnt_conta_e;
        base_l  = cnt_conta_l;
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p <= r; p++) begin
                play(mem[p], "win");
            end
        end
        wait_state(4'hA, 5, "win_state");
        chk("win_flags", 8'({pronto, acertou, errou, timeout}), 8'b1100);
        chk("win_contaE", 8'(cnt_conta_e - base_e), 8'd6);
        chk("win_contaL", 8'(cnt_conta_l - base_l), 8'd3);
        tick;
        chk("win_holds", 8'(db_estado), 8'hA);

        // Test 3: wrong play in round 1, position 1; restart clears L.
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        chk("restart_prep", 8'(db_estado), 8'h1);
        play(mem[0], "err_r0");
        play(mem[0], "err_r1p0");
        play(mem[1] ^ 2'd1, "err_r1p1");
        tick;
        chk("err_state", 8'(db_estado), 8'hB);
        chk("err_flags", 8'({pronto, acertou, errou, timeout}), 8'b1010);
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        chk("err_restart_prep", 8'(db_estado), 8'h1);
        tick;
        chk("err_restart_rodada", 8'(db_estado), 8'h2);
        chk("err_restart_L", 8'(l_q), 8'd0);

        // Test 4a: no play for 8 cycles in espera -> fim_timeout.
        tick;
        chk("tmo_espera_entry", 8'(db_estado), 8'h3);
        for (int i = 0; i < 7; i++) tick;
        chk("tmo_espera_cycle8", 8'(db_estado), 8'h3);
        tick;
        chk("tmo_state", 8'(db_estado), 8'hC);
        chk("tmo_flags", 8'({pronto, acertou, errou, timeout}), 8'b1001);

        // Test 4b: play on the timeout cycle wins over the timeout.
        iniciar = 1'b1;
        tick;
        iniciar = 1'b0;
        tick;
        tick;
        chk("jp_tmo_espera", 8'(db_estado), 8'h3);
        for (int i = 0; i < 7; i++) tick;
        jogada = 1'b1;
        botao  = mem[0];
        tick;
        chk("jp_beats_tmo", 8'(db_estado), 8'h4);
        jogada = 1'b0;
        tick;
        chk("jp_tmo_comparacao", 8'(db_estado), 8'h5);
        tick;
        chk("jp_tmo_proxima_rodada", 8'(db_estado), 8'h7);

        // Test 5: held button through proximo produces no new play.
        wait_state(4'h3, 5, "held_espera");
        jogada = 1'b1;
        botao  = mem[0];
        tick;
        chk("held_registra", 8'(db_estado), 8'h4);
        tick;
        chk("held_comparacao", 8'(db_estado), 8'h5);
        tick;
        chk("held_proximo", 8'(db_estado), 8'h6);
        tick;
        tick;
        tick;
        chk("held_no_registra", 8'({db_estado, registraR}), 8'({4'h3, 1'b0}));
        jogada = 1'b0;
        tick;
        chk("held_released", 8'(db_estado), 8'h3);
        jogada = 1'b1;
        botao  = mem[1];
        tick;
        chk("repress_registra", 8'(db_estado), 8'h4);
        jogada = 1'b0;
        tick;
        chk("repress_comparacao", 8'(db_estado), 8'h5);
        jogada = 1'b1;
        tick;
        chk("press_in_cmp_proxima", 8'(db_estado), 8'h7);
        tick;
        tick;
        chk("press_in_cmp_espera", 8'(db_estado), 8'h3);
        tick;
        chk("press_in_cmp_ignored", 8'(db_estado), 8'h3);
        jogada = 1'b0;

        // Test 6: illegal state code recovers to inicial.
        force dut.estado_q = estado_t'(4'h9);
        #1;
        chk("illegal_db", 8'(db_estado), 8'hF);
        chk("illegal_strobes", 8'({zeraE, contaE, zeraL, contaL, zeraR, registraR, pronto}), 8'h0);
        release dut.estado_q;
        tick;
        chk("illegal_recover", 8'(db_estado), 8'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
